// File: rtl/posit_encoder_pkg.sv
// Shared posit types and helpers for the encoder datapath.
package posit_encoder_pkg;

  typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;

  typedef enum logic [1:0] {SAT_NONE, SAT_MAX, SAT_MIN} posit_sat_t;

  localparam int unsigned MaxWidth = 32;

  function automatic logic [MaxWidth-1:0] two_comp(logic [MaxWidth-1:0] x);
    return ~x + MaxWidth'(1);
  endfunction

  // NaR pattern: a single 1 in the sign position of a width-bit posit.
  function automatic logic [MaxWidth-1:0] posit_nar(int unsigned width);
    return MaxWidth'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on the posit magnitude, clamped to [minpos, maxpos].
module posit_round_rne import posit_encoder_pkg::*; #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-2:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  posit_sat_t       sat,
  output logic [WIDTH-2:0] rounded
);

  localparam logic [WIDTH-2:0] MaxPos = '1;
  localparam logic [WIDTH-2:0] MinPos = (WIDTH-1)'(1);

  logic             inc;
  logic [WIDTH-1:0] sum;

  always_comb begin
    inc     = guard & (mag[0] | sticky);
    sum     = {1'b0, mag} + {{(WIDTH-1){1'b0}}, inc};
    rounded = sum[WIDTH-2:0];
    unique case (sat)
      SAT_MAX: rounded = MaxPos;
      SAT_MIN: rounded = MinPos;
      default: begin
        // A nonzero value must never round into the sign bit or down to zero.
        if (sum[WIDTH-1]) begin
          rounded = MaxPos;
        end else if (sum[WIDTH-2:0] == '0) begin
          rounded = MinPos;
        end
      end
    endcase
  end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage valid/ready posit encoder: stage 1 builds the regime/exponent/fraction
// bitstream, stage 2 rounds, applies sign and substitutes zero/NaR.
module posit_encoder import posit_encoder_pkg::*; #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned EN    = 1,
  parameter int unsigned W_REG = $clog2(WIDTH) + 1,
  parameter int unsigned W_EXP = $clog2(WIDTH) + 1,
  parameter int unsigned W_MAN = WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  sign_t                   in_sign,
  input  logic signed [W_REG-1:0] in_regime,
  input  logic        [W_EXP-1:0] in_exponent,
  input  logic        [W_MAN-1:0] in_mantissa,
  input  logic                    in_zero,
  input  logic                    in_nar,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] out_posit
);

  localparam int unsigned MW    = WIDTH - 1;
  localparam int unsigned TailW = EN + W_MAN - 1;
  localparam int unsigned SW    = MW + TailW;
  localparam logic [MaxWidth-1:0] NarWord = posit_nar(WIDTH);

  logic adv;

  // Stage 1 combinational
  int              k;
  logic [31:0]     k_mag;
  logic [SW-1:0]   regime_bits;
  logic [SW-1:0]   tail_bits;
  logic [SW-1:0]   stream;
  posit_sat_t      sat_d;

  // Stage 1 registers
  logic            s1_valid_q;
  logic [MW-1:0]   s1_mag_q;
  logic            s1_guard_q;
  logic            s1_sticky_q;
  sign_t           s1_sign_q;
  logic            s1_zero_q;
  logic            s1_nar_q;
  posit_sat_t      s1_sat_q;

  // Stage 2
  logic [MW-1:0]        rounded;
  logic [MaxWidth-1:0]  neg_word;
  logic [WIDTH-1:0]     posit_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_posit_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

  always_comb begin
    k     = int'(in_regime);
    k_mag = (k < 0) ? two_comp(k) : k;
    sat_d = SAT_NONE;
    if (k >= int'(WIDTH) - 2) begin
      sat_d = SAT_MAX;
    end else if (k < 2 - int'(WIDTH)) begin
      sat_d = SAT_MIN;
    end
    // Regime run as a shifted constant: k+1 leading ones, or a lone 1 after -k zeros.
    if (k >= 0) begin
      regime_bits = ~({SW{1'b1}} >> (k_mag + 32'd1));
      tail_bits   = {in_exponent[EN-1:0], in_mantissa[W_MAN-2:0], {MW{1'b0}}}
                    >> (k_mag + 32'd2);
    end else begin
      regime_bits = {1'b1, {(SW-1){1'b0}}} >> k_mag;
      tail_bits   = {in_exponent[EN-1:0], in_mantissa[W_MAN-2:0], {MW{1'b0}}}
                    >> (k_mag + 32'd1);
    end
    stream = regime_bits | tail_bits;
  end

  posit_round_rne #(
    .WIDTH(WIDTH)
  ) u_round (
    .mag    (s1_mag_q),
    .guard  (s1_guard_q),
    .sticky (s1_sticky_q),
    .sat    (s1_sat_q),
    .rounded(rounded)
  );

  always_comb begin
    neg_word = two_comp(MaxWidth'({1'b0, rounded}));
    posit_d  = {1'b0, rounded};
    if (s1_nar_q) begin
      posit_d = NarWord[WIDTH-1:0];
    end else if (s1_zero_q) begin
      posit_d = '0;
    end else if (s1_sign_q == NEG) begin
      posit_d = neg_word[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_sign_q   <= POS;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      s1_sat_q    <= SAT_NONE;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      if (in_valid) begin
        s1_mag_q    <= stream[SW-1 -: MW];
        s1_guard_q  <= stream[SW-WIDTH];
        s1_sticky_q <= |stream[SW-WIDTH-1:0];
        s1_sign_q   <= in_sign;
        s1_zero_q   <= in_zero;
        s1_nar_q    <= in_nar;
        s1_sat_q    <= sat_d;
      end
      if (s1_valid_q) begin
        out_posit_q <= posit_d;
      end
    end
  end

  // Exponent bits above EN and the hidden bit are don't-cares by definition.
  logic unused_bits;
  assign unused_bits = ^{in_exponent[W_EXP-1:EN], in_mantissa[W_MAN-1],
                         neg_word[MaxWidth-1:WIDTH], NarWord[MaxWidth-1:WIDTH]};

endmodule

// File: tb/tb_posit_encoder.sv
// Bench for posit_encoder: directed vectors, back-pressure, reset and randomised
// streams checked against a bit-list reference encoder and a posit decoder model.
`timescale 1ns/1ps
module tb_posit_encoder;
  import posit_encoder_pkg::*;

  localparam int W      = 7;
  localparam int EN     = 1;
  localparam int WR     = 4;
  localparam int WE     = 4;
  localparam int WM     = 7;
  localparam int MaxPos = (1 << (W - 1)) - 1;

  typedef struct {
    bit neg;
    int k;
    int e;
    int man;
    bit zero;
    bit nar;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  sign_t                in_sign;
  logic signed [WR-1:0] in_regime;
  logic        [WE-1:0] in_exponent;
  logic        [WM-1:0] in_mantissa;
  logic                 in_zero;
  logic                 in_nar;
  logic                 out_valid;
  logic                 out_ready;
  logic        [W-1:0]  out_posit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  posit_encoder #(
    .WIDTH(W),
    .EN   (EN),
    .W_REG(WR),
    .W_EXP(WE),
    .W_MAN(WM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_regime  (in_regime),
    .in_exponent(in_exponent),
    .in_mantissa(in_mantissa),
    .in_zero    (in_zero),
    .in_nar     (in_nar),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_posit  (out_posit)
  );

  // Reference: list the magnitude bits in order, then round the first W-1 of them.
  function automatic int model_encode(beat_t b);
    bit bits[$];
    int mag;
    bit guard;
    bit sticky;
    if (b.nar) return 1 << (W - 1);
    if (b.zero) return 0;
    if (b.k >= W - 2) begin
      mag = MaxPos;
    end else if (b.k < -(W - 2)) begin
      mag = 1;
    end else begin
      if (b.k >= 0) begin
        for (int i = 0; i <= b.k; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -b.k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = EN - 1; i >= 0; i--) bits.push_back(b.e[i]);
      for (int i = WM - 2; i >= 0; i--) bits.push_back(b.man[i]);
      mag = 0;
      for (int i = 0; i < W - 1; i++) mag = mag * 2 + int'(bits[i]);
      guard  = bits[W - 1];
      sticky = 1'b0;
      for (int i = W; i < bits.size(); i++) sticky |= bits[i];
      if (guard && ((mag % 2 == 1) || sticky)) mag++;
      if (mag > MaxPos) mag = MaxPos;
      if (mag == 0) mag = 1;
    end
    return b.neg ? ((1 << W) - mag) % (1 << W) : mag;
  endfunction

  // Field decoder for a nonzero, non-NaR posit.
  function automatic beat_t decode_posit(int p);
    beat_t b;
    int m;
    int pos;
    int run;
    int first;
    b.zero = 1'b0;
    b.nar  = 1'b0;
    b.neg  = p[W - 1];
    m      = b.neg ? ((1 << W) - p) : p;
    pos    = W - 2;
    first  = m[pos];
    run    = 0;
    while (pos >= 0 && m[pos] == first) begin
      run++;
      pos--;
    end
    b.k = (first != 0) ? run - 1 : -run;
    pos--;
    b.e = 0;
    for (int i = EN - 1; i >= 0; i--) begin
      if (pos >= 0) b.e[i] = m[pos];
      pos--;
    end
    b.man = 1 << (WM - 1);
    for (int i = WM - 2; i >= 0; i--) begin
      if (pos >= 0) b.man[i] = m[pos];
      pos--;
    end
    return b;
  endfunction

  function automatic beat_t mk(bit neg, int k, int e, int man, bit zero, bit nar);
    beat_t b;
    b.neg  = neg;
    b.k    = k;
    b.e    = e;
    b.man  = man;
    b.zero = zero;
    b.nar  = nar;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_sign     = b.neg ? NEG : POS;
    in_regime   = WR'(b.k);
    in_exponent = WE'(b.e);
    in_mantissa = WM'(b.man);
    in_zero     = b.zero;
    in_nar      = b.nar;
  endtask

  // Single beat into an idle pipeline; res stays X if no output appears.
  task automatic encode_one(input beat_t b, output logic [W-1:0] res, output int lat);
    @(negedge clk);
    drive(b);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    res       = 'x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        res = out_posit;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic stream_run(input beat_t beats[$], input int ready_pct,
                            output logic [W-1:0] got[$]);
    int idx = 0;
    int budget = beats.size() * 20 + 50;
    got.delete();
    for (int c = 0; c < budget && got.size() < beats.size(); c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < ready_pct);
      if (idx < beats.size()) begin
        drive(beats[idx]);
        in_valid = ($urandom_range(3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      #4;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) got.push_back(out_posit);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(mk(0, 0, 0, 64, 0, 0));
    #12;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    if (out_valid !== 1'b0) errors++;
    checks++;
    if (out_posit !== 7'h00) begin
      $display("FAIL reset_out_posit: got %h expected 00", out_posit);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      errors++;
    end
  endtask

  task automatic test_exact();
    logic [W-1:0] res;
    int lat;
    encode_one(mk(0, 0, 1, 7'b1101000, 0, 0), res, lat);
    checks++;
    if (res !== 7'h2D) begin
      $display("FAIL exact_pos: got %h expected 2d", res);
      errors++;
    end
    checks++;
    if (lat != 2) begin
      $display("FAIL latency: got %0d expected 2", lat);
      errors++;
    end
    encode_one(mk(1, 0, 1, 7'b1101000, 0, 0), res, lat);
    checks++;
    if (res !== 7'h53) begin
      $display("FAIL exact_neg: got %h expected 53", res);
      errors++;
    end
  endtask

  task automatic test_rounding();
    logic [W-1:0] res;
    int lat;
    encode_one(mk(0, 0, 0, 7'b1111100, 0, 0), res, lat);
    checks++;
    if (res !== 7'h28) begin
      $display("FAIL round_up: got %h expected 28", res);
      errors++;
    end
    encode_one(mk(0, 0, 0, 7'b1110100, 0, 0), res, lat);
    checks++;
    if (res !== 7'h26) begin
      $display("FAIL round_tie_even: got %h expected 26", res);
      errors++;
    end
  endtask

  task automatic test_saturation();
    beat_t        vec [6];
    logic [W-1:0] want [6];
    logic [W-1:0] res;
    int lat;
    vec[0] = mk(0, 5, 0, 64, 0, 0);  want[0] = 7'h3F;
    vec[1] = mk(0, 7, 0, 64, 0, 0);  want[1] = 7'h3F;
    vec[2] = mk(0, -5, 0, 64, 0, 0); want[2] = 7'h01;
    vec[3] = mk(0, -8, 0, 64, 0, 0); want[3] = 7'h01;
    vec[4] = mk(0, 1, 1, 99, 1, 0);  want[4] = 7'h00;
    vec[5] = mk(1, 1, 1, 99, 1, 1);  want[5] = 7'h40;
    for (int i = 0; i < 6; i++) begin
      encode_one(vec[i], res, lat);
      checks++;
      if (res !== want[i]) begin
        $display("FAIL saturation_special[%0d]: got %h expected %h", i, res, want[i]);
        errors++;
      end
    end
  endtask

  task automatic test_back_pressure();
    beat_t        beats [4];
    beat_t        pend [$];
    logic [W-1:0] got [$];
    logic [W-1:0] prev = '0;
    logic         stalled_prev = 1'b0;
    int           n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      beats[i] = mk($urandom_range(1), $urandom_range(8) - 4, $urandom_range(1),
                    $urandom_range(127), 0, 0);
      pend.push_back(beats[i]);
    end
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      if (pend.size() > 0) begin
        drive(pend[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #4;
      if (stalled_prev) begin
        checks++;
        if (out_posit !== prev) begin
          $display("FAIL stall_hold c%0d: got %h expected %h", c, out_posit, prev);
          errors++;
        end
      end
      if (out_valid && !out_ready) begin
        n_stall++;
        checks++;
        if (in_ready !== 1'b0) begin
          $display("FAIL stall_in_ready c%0d: got %b expected 0", c, in_ready);
          errors++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev         = out_posit;
      if (in_valid && in_ready) void'(pend.pop_front());
      if (out_valid && out_ready) got.push_back(out_posit);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n_stall != 3) begin
      $display("FAIL stall_cycles: got %0d expected 3", n_stall);
      errors++;
    end
    checks++;
    if (got.size() != 4) begin
      $display("FAIL bp_count: got %0d expected 4", got.size());
      errors++;
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== W'(model_encode(beats[i]))) begin
        $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i],
                 W'(model_encode(beats[i])));
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int lat;
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drive(mk(0, 1, 0, 64, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(mk(1, 2, 1, 80, 0, 0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL pre_reset_valid: got %b expected 1", out_valid);
      errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL async_reset_valid: got %b expected 0", out_valid);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      $display("FAIL stale_after_reset: got %0d valid cycles expected 0", stale);
      errors++;
    end
    encode_one(mk(0, 0, 1, 7'b1101000, 0, 0), res, lat);
    checks++;
    if (res !== 7'h2D) begin
      $display("FAIL post_reset_beat: got %h expected 2d", res);
      errors++;
    end
  endtask

  task automatic test_random_model();
    beat_t        beats [$];
    logic [W-1:0] got [$];
    beat_t        b;
    for (int i = 0; i < 200; i++) begin
      b = mk($urandom_range(1), int'($urandom_range(15)) - 8, $urandom_range(15),
             $urandom_range(127), ($urandom_range(15) == 0), ($urandom_range(15) == 0));
      beats.push_back(b);
    end
    stream_run(beats, 70, got);
    checks++;
    if (got.size() != beats.size()) begin
      $display("FAIL random_count: got %0d expected %0d", got.size(), beats.size());
      errors++;
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(model_encode(beats[i]))) begin
        $display("FAIL random[%0d] k=%0d e=%0d man=%h: got %h expected %h", i, beats[i].k,
                 beats[i].e, beats[i].man, got[i], W'(model_encode(beats[i])));
        errors++;
      end
    end
  endtask

  task automatic test_round_trip();
    int           ps [$];
    beat_t        beats [$];
    logic [W-1:0] got [$];
    int           j;
    int           tmp;
    for (int p = 1; p < (1 << W); p++) begin
      if (p != (1 << (W - 1))) ps.push_back(p);
    end
    for (int i = ps.size() - 1; i > 0; i--) begin
      j     = $urandom_range(i);
      tmp   = ps[i];
      ps[i] = ps[j];
      ps[j] = tmp;
    end
    foreach (ps[i]) beats.push_back(decode_posit(ps[i]));
    stream_run(beats, 50, got);
    checks++;
    if (got.size() != ps.size()) begin
      $display("FAIL roundtrip_count: got %0d expected %0d", got.size(), ps.size());
      errors++;
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(ps[i])) begin
        $display("FAIL roundtrip[%0d]: got %h expected %h", i, got[i], W'(ps[i]));
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_rounding();
    test_saturation();
    test_back_pressure();
    test_reset_mid();
    test_random_model();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
